// File: rtl/snd_write_sched_if.sv
// Bus bundle for snd_write_sched: CPU command port plus PSG chip pins.
// master = CPU/board side, slave = scheduler.
interface snd_write_sched_if;
  logic       CPU_WE;
  logic [7:0] CPU_WD;
  logic       CPU_FULL;
  logic       OVF;
  logic       SN_CS;
  logic       SN_WR;
  logic [7:0] SN_D;
  logic       BUSY;

  modport master (
    output CPU_WE,
    output CPU_WD,
    input  CPU_FULL,
    input  OVF,
    input  SN_CS,
    input  SN_WR,
    input  SN_D,
    input  BUSY
  );

  modport slave (
    input  CPU_WE,
    input  CPU_WD,
    output CPU_FULL,
    output OVF,
    output SN_CS,
    output SN_WR,
    output SN_D,
    output BUSY
  );
endinterface

// File: rtl/snd_write_sched.sv
// PSG write scheduler: 4-deep command FIFO feeding timed SN_CS/SN_WR strobes.
// Ports: CPUCL, reset_n (async low), bus (slave). Option: SND_INIT_MUTE_EN.
module snd_write_sched #(
  parameter int HOLD = 32,
  parameter int GAP  = 4
) (
  input  logic              CPUCL,
  input  logic              reset_n,
  snd_write_sched_if.slave  bus
);

`ifdef SND_INIT_MUTE_EN
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_WRITE = 2'd2,
    S_GAP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd1,
    S_WRITE = 2'd2,
    S_GAP   = 2'd3
  } state_t;
`endif

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

  logic [7:0] mem [4];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [2:0] count;
  logic [2:0] count_d;
  logic       full_q;
  logic       ovf_q;
  logic       push;
  logic       pop;
  logic       drop;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] tmr_q;
  logic [7:0] tmr_d;
  logic       cs_q;
  logic       cs_d;
  logic       wr_q;
  logic       wr_d;
  logic [7:0] d_q;
  logic [7:0] d_d;

`ifdef SND_INIT_MUTE_EN
  logic [1:0] idx_q;
  logic [1:0] idx_d;
  logic       mute_q;
  logic       mute_d;
`endif

  function automatic logic [2:0] ptr_inc(
    input logic [2:0] p
  );
    return (p == 3'd3) ? 3'd0 : p + 3'd1;
  endfunction

  // A full FIFO still accepts a byte when the
  // scheduler pops at the same edge.
  assign push = bus.CPU_WE && (!full_q || pop);
  assign drop = bus.CPU_WE && full_q && !pop;

  always_comb begin
    count_d = count;
    unique case ({push, pop})
      2'b10:   count_d = count + 3'd1;
      2'b01:   count_d = count - 3'd1;
      default: count_d = count;
    endcase
  end

  always_ff @(posedge CPUCL or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 3'd0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[1:0]] <= bus.CPU_WD;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count  <= count_d;
      full_q <= (count_d == 3'd4);
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    d_d     = d_q;
    pop     = 1'b0;
`ifdef SND_INIT_MUTE_EN
    idx_d   = idx_q;
    mute_d  = mute_q;
`endif
    unique case (state_q)
`ifdef SND_INIT_MUTE_EN
      // Mute bytes are 1cc11111: channel idx,
      // attenuation register, volume off.
      S_INIT: begin
        state_d = S_WRITE;
        tmr_d   = HOLD_M1;
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        d_d     = {1'b1, idx_q, 5'h1F};
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          mute_d = 1'b0;
        end
      end
`endif
      S_IDLE: begin
        if (count != 3'd0) begin
          pop     = 1'b1;
          state_d = S_WRITE;
          tmr_d   = HOLD_M1;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          d_d     = mem[rd_ptr[1:0]];
        end
      end
      S_WRITE: begin
        if (tmr_q == 8'd0) begin
          state_d = S_GAP;
          tmr_d   = GAP_M1;
          cs_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_GAP: begin
        if (tmr_q == 8'd0) begin
`ifdef SND_INIT_MUTE_EN
          state_d = mute_q ? S_INIT : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CPUCL or negedge reset_n) begin
    if (!reset_n) begin
`ifdef SND_INIT_MUTE_EN
      state_q <= S_INIT;
      idx_q   <= 2'd0;
      mute_q  <= 1'b1;
`else
      state_q <= S_IDLE;
`endif
      tmr_q   <= 8'd0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      d_q     <= 8'h00;
    end else begin
      state_q <= state_d;
`ifdef SND_INIT_MUTE_EN
      idx_q   <= idx_d;
      mute_q  <= mute_d;
`endif
      tmr_q   <= tmr_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      d_q     <= d_d;
    end
  end

  assign bus.CPU_FULL = full_q;
  assign bus.OVF      = ovf_q;
  assign bus.SN_CS    = cs_q;
  assign bus.SN_WR    = wr_q;
  assign bus.SN_D     = d_q;
  assign bus.BUSY     = !((state_q == S_IDLE)
                       && (count == 3'd0));

endmodule

// File: tb/tb_snd_write_sched.sv
// Scoreboard bench for snd_write_sched: default-timing and HOLD=2/GAP=1 units.
// Expected strobes (byte, start cycle) are queued by stimulus, checked by monitor.
`timescale 1ns/1ps
module tb_snd_write_sched;
  localparam int H0 = 32;
  localparam int G0 = 4;
  localparam int H1 = 2;
  localparam int G1 = 1;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t       exp_q [2][$];
  logic       hi [2];
  int         len [2];
  logic [7:0] dat [2];
  int         hold_p [2];

  snd_write_sched_if b0 ();
  snd_write_sched_if b1 ();

  snd_write_sched #(.HOLD(H0), .GAP(G0)) u_dut (
    .CPUCL   (clk),
    .reset_n (rst_n),
    .bus     (b0)
  );

  snd_write_sched #(.HOLD(H1), .GAP(G1)) u_fast (
    .CPUCL   (clk),
    .reset_n (rst_n),
    .bus     (b1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic       w [2];
    logic       c [2];
    logic [7:0] dd [2];
    exp_t       e;
    w[0] = b0.SN_WR; c[0] = b0.SN_CS; dd[0] = b0.SN_D;
    w[1] = b1.SN_WR; c[1] = b1.SN_CS; dd[1] = b1.SN_D;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        hi[i] = 1'b0;
      end else if (w[i] && !hi[i]) begin
        hi[i]  = 1'b1;
        len[i] = 1;
        dat[i] = dd[i];
        if (exp_q[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe u%0d: got %0h want none cyc %0d",
                   i, dd[i], cyc);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("strobe_data u%0d", i), 32'(dd[i]), 32'(e.data));
          if (e.start >= 0)
            check($sformatf("strobe_start u%0d", i), cyc, e.start);
          check($sformatf("cs_high u%0d", i), 32'(c[i]), 1);
        end
      end else if (w[i] && hi[i]) begin
        len[i]++;
        check($sformatf("strobe_stable u%0d", i),
              {23'd0, c[i], dd[i]}, {23'd0, 1'b1, dat[i]});
      end else if (!w[i] && hi[i]) begin
        hi[i] = 1'b0;
        check($sformatf("strobe_len u%0d", i), len[i], hold_p[i]);
        check($sformatf("cs_low u%0d", i), 32'(c[i]), 0);
      end
    end
  end

  task automatic chk_reset();
    logic busy_rst;
`ifdef SND_INIT_MUTE_EN
    busy_rst = 1'b1;
`else
    busy_rst = 1'b0;
`endif
    check("rst_cs",   32'(b0.SN_CS),    0);
    check("rst_wr",   32'(b0.SN_WR),    0);
    check("rst_ovf",  32'(b0.OVF),      0);
    check("rst_full", 32'(b0.CPU_FULL), 0);
    check("rst_d",    32'(b0.SN_D),     0);
    check("rst_busy", 32'(b0.BUSY),     32'(busy_rst));
    check("rst_wr_f", 32'(b1.SN_WR),    0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((b0.BUSY || b1.BUSY) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL %s: busy after %0d cycles want idle", name, n);
    end
  endtask

  task automatic do_reset();
    int r;
    rst_n = 1'b0;
    #1;
    chk_reset();
    step();
    step();
    rst_n = 1'b1;
    r = cyc;
`ifdef SND_INIT_MUTE_EN
    for (int j = 0; j < 4; j++) begin
      logic [7:0] mb;
      mb = {1'b1, 2'(j), 5'h1F};
      exp_q[0].push_back('{mb, r + 1 + j * (H0 + G0 + 1)});
      exp_q[1].push_back('{mb, r + 1 + j * (H1 + G1 + 1)});
    end
`endif
    wait_idle("init_done");
    check("idle_busy", 32'(b0.BUSY), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    hold_p[0] = H0;
    hold_p[1] = H1;
    hi[0] = 1'b0;
    hi[1] = 1'b0;
    b0.CPU_WE = 1'b0;
    b0.CPU_WD = 8'h00;
    b1.CPU_WE = 1'b0;
    b1.CPU_WD = 8'h00;
    step();
    do_reset();

    // single command, one-cycle latency
    step();
    k = cyc;
    b0.CPU_WE = 1'b1;
    b0.CPU_WD = 8'h8E;
    exp_q[0].push_back('{8'h8E, k + 2});
    step();
    b0.CPU_WE = 1'b0;
    wait_idle("single");
    check("single_idle_cyc", cyc, k + 2 + H0 + G0);

    // six back-to-back pushes, last one dropped
    step();
    k = cyc;
    for (int v = 1; v <= 6; v++) begin
      if (v == 6) begin
        check("pre_ovf", 32'(b0.OVF), 0);
        check("pre_full", 32'(b0.CPU_FULL), 1);
      end
      b0.CPU_WE = 1'b1;
      b0.CPU_WD = 8'(v);
      if (v <= 5)
        exp_q[0].push_back('{8'(v), k + 2 + (v - 1) * (H0 + G0 + 1)});
      step();
    end
    b0.CPU_WE = 1'b0;
    check("drop_ovf", 32'(b0.OVF), 1);
    check("drop_full", 32'(b0.CPU_FULL), 1);
    wait_idle("six");
    check("ovf_sticky", 32'(b0.OVF), 1);
    check("full_clear", 32'(b0.CPU_FULL), 0);

    // push while full on a pop edge
    do_reset();
    step();
    k = cyc;
    for (int j = 0; j < 5; j++) begin
      b0.CPU_WE = 1'b1;
      b0.CPU_WD = 8'hA0 + 8'(j);
      exp_q[0].push_back('{8'hA0 + 8'(j),
                          k + 2 + j * (H0 + G0 + 1)});
      step();
    end
    b0.CPU_WE = 1'b0;
    while (cyc < k + 1 + H0 + G0 + 1) step();
    check("full_before_pop", 32'(b0.CPU_FULL), 1);
    b0.CPU_WE = 1'b1;
    b0.CPU_WD = 8'hA5;
    exp_q[0].push_back('{8'hA5, k + 2 + 5 * (H0 + G0 + 1)});
    step();
    b0.CPU_WE = 1'b0;
    check("coinc_ovf", 32'(b0.OVF), 0);
    check("coinc_full", 32'(b0.CPU_FULL), 1);
    wait_idle("coinc");
    check("coinc_ovf_end", 32'(b0.OVF), 0);

    // reset in the 10th WRITE cycle with 3 queued
    step();
    k = cyc;
    for (int j = 0; j < 4; j++) begin
      b0.CPU_WE = 1'b1;
      b0.CPU_WD = 8'hB0 + 8'(j);
      if (j == 0) exp_q[0].push_back('{8'hB0, k + 2});
      step();
    end
    b0.CPU_WE = 1'b0;
    while (cyc < k + 2 + 9) step();
    check("mid_write_wr", 32'(b0.SN_WR), 1);
    check("mid_write_full", 32'(b0.CPU_FULL), 0);
    do_reset();
    repeat (3 * (H0 + G0 + 1)) step();
    check("flush_q0", exp_q[0].size(), 0);
    check("flush_busy", 32'(b0.BUSY), 0);

    // short timing instance: HOLD=2, GAP=1
    step();
    k = cyc;
    b1.CPU_WE = 1'b1;
    b1.CPU_WD = 8'hC0;
    exp_q[1].push_back('{8'hC0, k + 2});
    step();
    b1.CPU_WD = 8'hC1;
    exp_q[1].push_back('{8'hC1, k + 2 + H1 + G1 + 1});
    step();
    b1.CPU_WE = 1'b0;
    wait_idle("fast");
    check("fast_idle_cyc", cyc, k + 2 + (H1 + G1 + 1) + H1 + G1);

    step();
    check("end_q0", exp_q[0].size(), 0);
    check("end_q1", exp_q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
